// File: rtl/main_memory.sv
// Multi-cycle backing memory for the set-associative cache controller.
// Block reads after a fixed latency, word writes, and posted write-through pulses.
module main_memory #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          memoryAccessM,
  input  logic                          readM,
  input  logic                          writeM,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             writeData,
  output logic                          memoryReadyM,
  output logic [BLOCK_WORDS*DATA_W-1:0] readData,
  output logic                          busy
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int OFF_W     = $clog2(BLOCK_WORDS);
  localparam int CNT_W     = $clog2(LATENCY + 1);
  localparam int WAIT_INIT = (LATENCY > 2) ? LATENCY - 3 : 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  // Power-up contents are the word index; reset never touches the array.
  mem_t mem_q = mem_init();

  logic [1:0]                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          held_q, held_d;
  logic [1:0]                    op_q, op_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic                          ready_q, ready_d;
  logic                          busy_q, busy_d;
  logic [BLOCK_WORDS*DATA_W-1:0] rdata_q, rdata_d;
  logic [BLOCK_WORDS*DATA_W-1:0] block;
  logic                          we;

  always_comb begin
    block = '0;
    for (int unsigned i = 0; i < BLOCK_WORDS; i++)
      block[i*DATA_W +: DATA_W] = mem_q[base_q | ADDR_W'(i)];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    op_d    = op_q;
    base_d  = base_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memoryAccessM) begin
          state_d = ST_ACCEPT;
          op_d    = readM ? OP_READ : (writeM ? OP_WRITE : OP_NOP);
          base_d  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          we      = !readM && writeM;
        end
      end
      ST_ACCEPT: begin
        held_d = memoryAccessM;
        // Short latencies skip WAIT, so ready must use the held value sampled this edge.
        if (LATENCY <= 2) begin
          state_d = ST_DONE;
          ready_d = memoryAccessM;
          if (op_q == OP_READ) rdata_d = block;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_INIT);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          ready_d = held_q;
          if (op_q == OP_READ) rdata_d = block;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      op_q    <= OP_NOP;
      base_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      op_q    <= op_d;
      base_q  <= base_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[addr] <= writeData;
  end

  assign memoryReadyM = ready_q;
  assign readData     = rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: a LATENCY=4 and a LATENCY=1 instance
// checked against an array model of memory contents and cycle-count timing rules.
module tb_main_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         acc  [2];
  logic         rd   [2];
  logic         wr   [2];
  logic [9:0]   ad   [2];
  logic [31:0]  wd   [2];
  logic         rdy  [2];
  logic         bsy  [2];
  logic [127:0] rdat [2];

  main_memory #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .memoryAccessM(acc[0]), .readM(rd[0]), .writeM(wr[0]),
    .addr(ad[0]), .writeData(wd[0]), .memoryReadyM(rdy[0]), .readData(rdat[0]),
    .busy(bsy[0])
  );

  main_memory #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .memoryAccessM(acc[1]), .readM(rd[1]), .writeM(wr[1]),
    .addr(ad[1]), .writeData(wd[1]), .memoryReadyM(rdy[1]), .readData(rdat[1]),
    .busy(bsy[1])
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [31:0]  ref_mem  [2][1024];
  logic [127:0] last_blk [2];
  // Cycles from the request cycle T to the ready cycle: max(LATENCY, 2).
  int           lat_exp  [2] = '{4, 2};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ref_block(input int s, input logic [9:0] a);
    logic [127:0] b;
    logic [9:0]   base;
    base = a & ~10'd3;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = ref_mem[s][base + 10'(w)];
    return b;
  endfunction

  task automatic drive(input int s, input bit a_on, input bit r, input bit w,
                       input logic [9:0] a, input logic [31:0] d);
    acc[s] = a_on; rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
  endtask

  // Called in the ready cycle: controller keeps access up one more cycle, then drops it.
  task automatic finish_req(input int s);
    check("rdata", rdat[s], last_blk[s]);
    tick();
    check("ready_one_cycle", rdy[s], 1'b0);
    check("idle_after_done", bsy[s], 1'b0);
    drive(s, 0, 0, 0, ad[s], wd[s]);
    tick();
    check("no_double_serve", {bsy[s], rdy[s]}, 2'b00);
  endtask

  task automatic req(input int s, input bit r, input bit w,
                     input logic [9:0] a, input logic [31:0] d);
    int n;
    bit seen;
    drive(s, 1, r, w, a, d);
    if (!r && w) ref_mem[s][a] = d;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (rdy[s]) seen = 1;
    end
    if (r) last_blk[s] = ref_block(s, a);
    check("latency", 128'(n), 128'(lat_exp[s]));
    finish_req(s);
  endtask

  // One-cycle write pulse, then a held read two cycles later; read completes at T+2L+1.
  task automatic posted_then_read(input logic [9:0] wa, input logic [31:0] d, input logic [9:0] ra);
    int c;
    bit seen;
    bit early;
    drive(0, 1, 0, 1, wa, d);
    ref_mem[0][wa] = d;
    tick();
    drive(0, 0, 0, 0, wa, d);
    check("posted_busy", bsy[0], 1'b1);
    tick();
    drive(0, 1, 1, 0, ra, 32'h0);
    c = 2;
    seen = 0;
    early = 0;
    while (!seen && c < 40) begin
      tick();
      c++;
      if (rdy[0]) begin
        seen = 1;
        if (c < 9) early = 1;
      end
    end
    last_blk[0] = ref_block(0, ra);
    check("posted_no_ready", early, 1'b0);
    check("posted_read_cycle", 128'(c), 128'(9));
    finish_req(0);
  endtask

  initial begin
    int spurious;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) ref_mem[s][i] = 32'(i);
      last_blk[s] = '0;
      drive(s, 0, 0, 0, 10'h0, 32'h0);
    end
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      check("reset_busy", bsy[s], 1'b0);
      check("reset_ready", rdy[s], 1'b0);
      check("reset_rdata", rdat[s], 128'h0);
    end
    rst = 1'b0;
    tick();

    // Read miss of 0x006 returns block 4..7.
    req(0, 1, 0, 10'h006, 32'h0);
    check("blk_006", rdat[0], {32'd7, 32'd6, 32'd5, 32'd4});

    // Write miss then block read.
    req(0, 0, 1, 10'h005, 32'hDEADBEEF);
    check("rdata_held_over_write", rdat[0], {32'd7, 32'd6, 32'd5, 32'd4});
    req(0, 1, 0, 10'h004, 32'h0);
    check("blk_004", rdat[0], {32'd7, 32'd6, 32'hDEADBEEF, 32'd4});

    posted_then_read(10'h009, 32'h1234, 10'h008);
    check("blk_008_w1", rdat[0][63:32], 32'h1234);

    // Back-to-back reads, read-wins-over-write, and a no-op.
    req(0, 1, 0, 10'h010, 32'h0);
    req(0, 1, 0, 10'h3FF, 32'h0);
    req(0, 1, 1, 10'h011, 32'hCAFE0000);
    req(0, 0, 0, 10'h020, 32'h0);

    // Reset in WAIT drops the read.
    drive(0, 1, 1, 0, 10'h030, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_busy", bsy[0], 1'b0);
    check("rst_ready", rdy[0], 1'b0);
    check("rst_rdata", rdat[0], 128'h0);
    rst = 1'b0;
    last_blk[0] = '0;
    last_blk[1] = '0;
    drive(0, 0, 0, 0, 10'h0, 32'h0);
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rdy[0] || bsy[0]) spurious++;
    end
    check("rst_no_spurious", 128'(spurious), 128'(0));
    req(0, 1, 0, 10'h030, 32'h0);

    // Randomised mix of reads, writes and posted writes against the model.
    for (int k = 0; k < 16; k++) begin
      logic [9:0]  a;
      logic [9:0]  b;
      logic [31:0] d;
      int          op;
      a  = 10'($urandom);
      b  = 10'($urandom);
      d  = $urandom;
      op = $urandom_range(0, 2);
      if (op == 0) req(0, 1, 0, a, 32'h0);
      else if (op == 1) begin
        req(0, 0, 1, a, d);
        req(0, 1, 0, a, 32'h0);
      end else posted_then_read(a, d, b);
    end

    // LATENCY = 1 build: ready in the cycle after ACCEPT.
    req(1, 1, 0, 10'h01A, 32'h0);
    check("lat1_blk", rdat[1], {32'h1B, 32'h1A, 32'h19, 32'h18});
    for (int k = 0; k < 4; k++) begin
      logic [9:0]  a;
      logic [31:0] d;
      a = 10'($urandom);
      d = $urandom;
      req(1, 0, 1, a, d);
      req(1, 1, 0, a, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
